// File: rtl/bsg_manycore_pkt_decode.sv
// Receive-side manycore packet endpoint: 2-entry input FIFO feeding a serial FSM that issues
// loads, masked stores and swaps to local memory. Swaps are enabled by BSG_MANYCORE_PKT_DECODE_SWAP_EN.
module bsg_manycore_pkt_decode #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 16,
  parameter int packet_width_lp = addr_width_p + 2 + (data_width_p >> 3) + data_width_p
                                  + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [packet_width_lp-1:0]   data_i,
  output logic                         ready_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  output logic                         mem_v_o,
  output logic                         mem_w_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic [data_width_p-1:0]      mem_data_o,
  output logic [(data_width_p>>3)-1:0] mem_mask_o,
  input  logic                         mem_yumi_i,
  input  logic [data_width_p-1:0]      mem_data_i,
  output logic                         ret_v_o,
  output logic [data_width_p-1:0]      ret_data_o,
  output logic [x_cord_width_p-1:0]    ret_x_o,
  output logic [y_cord_width_p-1:0]    ret_y_o,
  input  logic                         ret_ready_i,
  output logic                         err_o
);

  localparam int mask_width_lp = data_width_p >> 3;

`ifdef BSG_MANYCORE_PKT_DECODE_SWAP_EN
  localparam bit swap_en_lp = 1'b1;
`else
  localparam bit swap_en_lp = 1'b0;
`endif

  localparam logic [1:0] ePacketOp_remote_load    = 2'd0;
  localparam logic [1:0] ePacketOp_remote_store   = 2'd1;
  localparam logic [1:0] ePacketOp_remote_swap_aq = 2'd2;
  localparam logic [1:0] ePacketOp_remote_swap_rl = 2'd3;

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [1:0]                op;
    logic [mask_width_lp-1:0]  op_ex;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y_cord;
    logic [x_cord_width_p-1:0] src_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } packet_s;

  typedef enum logic [2:0] {
    eIdle,
    eIssue,
    eRdWait,
    eSwapWr,
    eResp
  } state_e;

  packet_s         fifo_mem_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;
  logic            enq, deq, fifo_empty;
  packet_s         head;

  state_e                  state_q, state_d;
  packet_s                 pkt_q, pkt_d;
  logic [data_width_p-1:0] ret_data_q, ret_data_d;

  logic head_is_swap, head_dest_ok, pkt_is_swap;

  assign ready_o    = (count_q != 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign enq        = v_i & ready_o;
  assign head       = fifo_mem_q[rd_ptr_q];

  assign head_is_swap = (head.op == ePacketOp_remote_swap_aq) | (head.op == ePacketOp_remote_swap_rl);
  assign head_dest_ok = (head.x_cord == my_x_i) & (head.y_cord == my_y_i);
  assign pkt_is_swap  = (pkt_q.op == ePacketOp_remote_swap_aq) | (pkt_q.op == ePacketOp_remote_swap_rl);

  // Payload storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (enq) wr_ptr_q <= ~wr_ptr_q;
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= eIdle;
      pkt_q      <= '0;
      ret_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      ret_data_q <= ret_data_d;
    end
  end

  // Strictly serial: nothing is popped until the current packet retires, which keeps swaps atomic.
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    ret_data_d = ret_data_q;
    deq        = 1'b0;
    err_o      = 1'b0;
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_mask_o = '0;
    ret_v_o    = 1'b0;
    ret_data_o = '0;
    ret_x_o    = '0;
    ret_y_o    = '0;

    case (state_q)
      eIdle: begin
        if (!fifo_empty) begin
          deq = 1'b1;
          if (!head_dest_ok || (head_is_swap && !swap_en_lp)) begin
            err_o = 1'b1;
          end else begin
            pkt_d   = head;
            state_d = eIssue;
          end
        end
      end

      eIssue: begin
        mem_v_o    = 1'b1;
        mem_addr_o = pkt_q.addr;
        if (pkt_q.op == ePacketOp_remote_store) begin
          mem_w_o    = 1'b1;
          mem_data_o = pkt_q.payload;
          mem_mask_o = pkt_q.op_ex;
          if (mem_yumi_i) state_d = eIdle;
        end else begin
          mem_mask_o = '1;
          if (mem_yumi_i) state_d = eRdWait;
        end
      end

      eRdWait: begin
        ret_data_d = mem_data_i;
        state_d    = (pkt_is_swap && swap_en_lp) ? eSwapWr : eResp;
      end

      eSwapWr: begin
        mem_v_o    = 1'b1;
        mem_w_o    = 1'b1;
        mem_addr_o = pkt_q.addr;
        mem_data_o = pkt_q.payload;
        mem_mask_o = '1;
        if (mem_yumi_i) state_d = eResp;
      end

      eResp: begin
        ret_v_o    = 1'b1;
        ret_data_o = ret_data_q;
        ret_x_o    = pkt_q.src_x_cord;
        ret_y_o    = pkt_q.src_y_cord;
        if (ret_ready_i) state_d = eIdle;
      end

      default: state_d = eIdle;
    endcase
  end

endmodule
